// File: rtl/counter_pkg.sv
// counter_pkg : shared state encoding and wrap helper for counter_checker (rev 1.0)
`default_nettype none

package counter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  // v+1 truncated to w bits; callers cast the result down to their own width
  function automatic logic [31:0] next_val(input logic [31:0] v, input int unsigned w);
    logic [31:0] mask;
    mask = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
    return (v + 32'd1) & mask;
  endfunction

endpackage

`default_nettype wire

// File: rtl/counter_checker_sat_counter.sv
// sat_counter : W-bit up-counter that holds at all-ones, with synchronous clear (rev 1.0)
`default_nettype none

module sat_counter
  import counter_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/counter_checker.sv
// counter_checker : checks a sampled up-counter for +1 steps, tracks lock and counts breaks (rev 1.0)
`default_nettype none

module counter_checker
  import counter_pkg::*;
#(
  parameter int WIDTH      = 2,
  parameter int LOCK_COUNT = 4,
  parameter int ERR_CNT_W  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 val_valid,
  input  logic [WIDTH-1:0]     val,
  input  logic                 clear,
  output logic                 locked,
  output logic                 err_pulse,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic [WIDTH-1:0]     expected
);

  localparam int GW = $clog2(LOCK_COUNT + 1);

  state_t         state, state_n;
  logic [GW-1:0]  good_cnt, good_n;
  logic [WIDTH-1:0] exp_n;
  logic           pulse_n;
  logic           err_inc;
  logic           match;

  // expected already holds prev+1, so prev itself need not be stored
  assign match = (val == expected);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      good_cnt  <= '0;
      expected  <= WIDTH'(1);
      err_pulse <= 1'b0;
      locked    <= 1'b0;
    end else begin
      state     <= state_n;
      good_cnt  <= good_n;
      expected  <= exp_n;
      err_pulse <= pulse_n;
      locked    <= (state_n == LOCKED);
    end
  end

  always_comb begin
    state_n = state;
    good_n  = good_cnt;
    exp_n   = expected;
    pulse_n = 1'b0;
    err_inc = 1'b0;
    if (clear) begin
      state_n = IDLE;
      good_n  = '0;
      exp_n   = WIDTH'(1);
    end else if (val_valid) begin
      exp_n = WIDTH'(next_val(32'(val), WIDTH));
      case (state)
        IDLE: begin
          state_n = ACQUIRE;
          good_n  = '0;
        end
        ACQUIRE: begin
          if (!match) begin
            good_n = '0;
          end else if (good_cnt == GW'(LOCK_COUNT - 1)) begin
            state_n = LOCKED;
            good_n  = '0;
          end else begin
            good_n = good_cnt + GW'(1);
          end
        end
        LOCKED: begin
          if (!match) begin
            pulse_n = 1'b1;
            err_inc = 1'b1;
            state_n = ACQUIRE;
            good_n  = '0;
          end
        end
        default: begin
          state_n = IDLE;
          good_n  = '0;
        end
      endcase
    end
  end

  sat_counter #(.W(ERR_CNT_W)) u_err_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (err_inc),
    .clr   (clear),
    .count (err_count)
  );

endmodule

`default_nettype wire

// File: tb/tb_counter_checker.sv
// tb_counter_checker : directed + random stimulus against a sample-history reference model (rev 1.0)
`default_nettype none

module tb_counter_checker;

  localparam int W  = 2;
  localparam int LC = 4;
  localparam int MOD = 1 << W;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic val_valid = 1'b0;
  logic [W-1:0] val = '0;
  logic clear = 1'b0;

  logic         locked_a, pulse_a, locked_b, pulse_b;
  logic [7:0]   errc_a;
  logic [1:0]   errc_b;
  logic [W-1:0] exp_a, exp_b;

  int n_assert = 0;
  int n_fail   = 0;

  // reference model: last sample, run of correct steps, lock flag, total breaks
  bit m_have;
  int m_ref, m_run, m_errs;
  bit m_lock, m_pulse;

  always #5 clk = ~clk;

  counter_checker #(.WIDTH(W), .LOCK_COUNT(LC), .ERR_CNT_W(8)) dut_a (
    .clk(clk), .rst(rst), .val_valid(val_valid), .val(val), .clear(clear),
    .locked(locked_a), .err_pulse(pulse_a), .err_count(errc_a), .expected(exp_a)
  );

  counter_checker #(.WIDTH(W), .LOCK_COUNT(LC), .ERR_CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .val_valid(val_valid), .val(val), .clear(clear),
    .locked(locked_b), .err_pulse(pulse_b), .err_count(errc_b), .expected(exp_b)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_have = 0; m_ref = 0; m_run = 0; m_errs = 0; m_lock = 0; m_pulse = 0;
  endtask

  task automatic model_step(input bit c, input bit v, input int x);
    m_pulse = 0;
    if (c) begin
      model_reset();
    end else if (v) begin
      if (!m_have) begin
        m_have = 1;
        m_run  = 0;
      end else if (x == (m_ref + 1) % MOD) begin
        if (!m_lock) begin
          m_run++;
          if (m_run == LC) begin
            m_lock = 1;
            m_run  = 0;
          end
        end
      end else begin
        if (m_lock) begin
          m_pulse = 1;
          m_errs++;
          m_lock = 0;
        end
        m_run = 0;
      end
      m_ref = x;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".locked_a"},  int'(locked_a), int'(m_lock));
    chk({tag, ".locked_b"},  int'(locked_b), int'(m_lock));
    chk({tag, ".pulse_a"},   int'(pulse_a),  int'(m_pulse));
    chk({tag, ".pulse_b"},   int'(pulse_b),  int'(m_pulse));
    chk({tag, ".errcnt_a"},  int'(errc_a),   (m_errs > 255) ? 255 : m_errs);
    chk({tag, ".errcnt_b"},  int'(errc_b),   (m_errs > 3) ? 3 : m_errs);
    chk({tag, ".expected_a"}, int'(exp_a),   (m_ref + 1) % MOD);
    chk({tag, ".expected_b"}, int'(exp_b),   (m_ref + 1) % MOD);
  endtask

  task automatic step(input string tag, input bit c, input bit v, input int x);
    clear = c; val_valid = v; val = W'(x);
    @(posedge clk);
    model_step(c, v, x);
    #1 check_all(tag);
  endtask

  task automatic feed_lock(input string tag, input int start);
    for (int i = 0; i <= LC; i++) step(tag, 1'b0, 1'b1, (start + i) % MOD);
  endtask

  // break from the current reference, then walk back to lock
  task automatic break_relock(input string tag);
    int b;
    b = (m_ref + 2) % MOD;
    step({tag, ".brk"}, 1'b0, 1'b1, b);
    for (int i = 1; i <= LC; i++) step({tag, ".relock"}, 1'b0, 1'b1, (b + i) % MOD);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1 check_all("reset");
    @(negedge clk) rst = 1'b1;
    #1;

    // lock from 0,1,2,3,0
    feed_lock("lock", 0);
    chk("lock.final", int'(locked_a), 1);
    chk("lock.exp", int'(exp_a), 1);

    // break while locked, then relock with 3,0,1,2
    step("brk", 1'b0, 1'b1, 2);
    chk("brk.pulse", int'(pulse_a), 1);
    step("brk.idle", 1'b0, 1'b0, 2);
    chk("brk.pulse_gone", int'(pulse_a), 0);
    step("relock", 1'b0, 1'b1, 3);
    step("relock", 1'b0, 1'b1, 0);
    step("relock", 1'b0, 1'b1, 1);
    step("relock", 1'b0, 1'b1, 2);
    chk("relock.errcnt", int'(errc_a), 1);

    // wrap across a gap of invalid cycles
    step("gap.3", 1'b0, 1'b1, 3);
    repeat (3) step("gap.hold", 1'b0, 1'b0, 2);
    step("gap.0", 1'b0, 1'b1, 0);
    chk("gap.locked", int'(locked_a), 1);

    // saturation on the 2-bit counter
    step("clr", 1'b1, 1'b0, 0);
    feed_lock("sat.lock", 0);
    for (int k = 0; k < 5; k++) break_relock("sat");
    chk("sat.errcnt_b", int'(errc_b), 3);
    chk("sat.errcnt_a", int'(errc_a), 5);

    // clear wins over a simultaneous valid sample
    step("clr2", 1'b1, 1'b0, 0);
    feed_lock("c.lock", 1);
    break_relock("c");
    break_relock("c");
    chk("c.errcnt", int'(errc_a), 2);
    step("c.clr_valid", 1'b1, 1'b1, (m_ref + 1) % MOD);
    chk("c.unlocked", int'(locked_a), 0);
    step("c.first", 1'b0, 1'b1, 3);
    step("c.second", 1'b0, 1'b1, 0);

    // asynchronous reset mid-cycle while locked
    feed_lock("ar.lock", 2);
    break_relock("ar");
    #3 rst = 1'b0;
    #1;
    model_reset();
    check_all("ar.async");
    @(posedge clk);
    #1 check_all("ar.held");
    #3 rst = 1'b1;
    feed_lock("ar.relock", 1);
    chk("ar.locked", int'(locked_a), 1);

    // random mostly-incrementing traffic
    for (int i = 0; i < 400; i++) begin
      bit c, v;
      int x;
      c = ($urandom_range(0, 49) == 0);
      v = ($urandom_range(0, 3) != 0);
      x = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, MOD - 1)) : (m_ref + 1) % MOD;
      step("rand", c, v, x);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/counter_checker.md
Name: counter_checker

Overview:
- Receive-side partner of the free-running WIDTH-bit up-counter: samples the counter's `val` bus and checks that each valid sample is the previous one plus 1, modulo 2^WIDTH.
- Acquires lock after a run of correct increments and flags sequence breaks while locked.
- Keeps a saturating error count.
- Sits beside the counter as a built-in self-check for post-synthesis netlist verification.

Parameters:
- WIDTH, 2, width of the sampled counter value.
- LOCK_COUNT, 4, consecutive correct increments needed to declare lock (>=1).
- ERR_CNT_W, 8, width of the saturating error counter.

Ports:
- clk  input  1  rising-edge clock, same domain as the counter.
- rst  input  1  asynchronous, active-low reset.
- val_valid  input  1  `val` is a sample to check this cycle.
- val  input  WIDTH  counter value under test.
- clear  input  1  synchronous soft clear, active-high.
- locked  output  1  checker is in LOCKED.
- err_pulse  output  1  one-cycle pulse on a sequence break while locked.
- err_count  output  ERR_CNT_W  saturating count of breaks detected while locked.
- expected  output  WIDTH  next expected value, equal to prev+1 mod 2^WIDTH.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, prev=0, good_cnt=0.
  - locked=0, err_pulse=0, err_count=0, expected=1.
- All outputs are registered. No combinational path from inputs to outputs.
- Arithmetic:
  - expected = prev+1, truncated to WIDTH bits, so all-ones wraps to 0.
  - match = (val == expected).
- FSM (evaluated only when val_valid=1; when val_valid=0, state, prev and good_cnt hold and err_pulse=0):
  - IDLE: store the sample, prev<=val, good_cnt<=0, go to ACQUIRE. No check is made on the first sample.
  - ACQUIRE, on match:
    - good_cnt<=good_cnt+1.
    - If good_cnt+1 == LOCK_COUNT, go to LOCKED and good_cnt<=0.
  - ACQUIRE, on mismatch: good_cnt<=0, stay in ACQUIRE, no error counted.
  - LOCKED, on match: stay in LOCKED.
  - LOCKED, on mismatch:
    - err_pulse<=1 for exactly the next cycle.
    - err_count increments, saturating at 2^ERR_CNT_W-1.
    - go to ACQUIRE with good_cnt<=0.
  - In every state, prev<=val on each valid sample, so a mismatched sample becomes the new reference.
- Latency:
  - err_pulse and locked change at the clock edge that samples the deciding `val`.
  - They are visible in the following cycle.
- clear:
  - Takes priority over val_valid in the same cycle.
  - Forces state=IDLE, good_cnt=0, err_count=0, err_pulse=0, locked=0, prev=0.
- Saturation: once err_count is all-ones, further errors still pulse err_pulse but the count holds.
- Counter-width rule: good_cnt is sized to hold LOCK_COUNT, i.e. clog2(LOCK_COUNT+1) bits.
- Reset during LOCKED or mid-acquire: immediate return to the reset values above. The first valid sample after release is treated as an IDLE sample.
- Two consecutive mismatches while locked produce one error, because the first one drops lock. Later mismatches only restart acquisition.

Decomposition:
- Shared package counter_pkg holds:
  - the state enum {IDLE, ACQUIRE, LOCKED}, 2-bit encoding;
  - the helper function for next-value wrap.
- Natural sub-module: sat_counter (parameter W; inputs inc and clr; output count; saturates at all-ones). Used for err_count.

Test Plan:
- Defaults. Reset, then valid samples 0,1,2,3,0 on consecutive cycles -> locked=1 after the 5th sample edge, err_count=0, expected=1.
- Locked at val=0, then feed 2 -> err_pulse high for one cycle, err_count=1, locked=0. Then feed 3,0,1,2 -> locked=1 again with err_count still 1.
- Wrap and gaps: feed 3, three cycles of val_valid=0 with val=2, then 0 -> counted as a match. err_pulse stays 0 during the gap and prev holds 3.
- ERR_CNT_W=2. Lock, inject a break, relock, and repeat 5 times -> five err_pulse pulses, err_count reads 1,2,3,3,3.
- clear=1 and val_valid=1 together while locked with err_count=2 -> next cycle state IDLE, locked=0, err_count=0, and that sample is ignored.
- Drive rst low asynchronously mid-cycle while locked -> locked and err_count drop to 0 immediately, before the next clk edge. After release, 1,2,3,0,1 relocks.
